alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, handshaked successor to the single-cycle execute-stage ALU of the pipelined CPU. It adds an extended operation set, registered results with status flags, and an iterative shift-add multiplier that holds the pipeline via valid/ready. It sits between the ID/EX register and the EX/MEM register. Single-cycle operations sustain one result per clock; multiply operations occupy the block for WIDTH cycles.

## Interface
- WIDTH, 32: datapath width; power of two, ≥ 8.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash: drop any operation in flight, including a pending result.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block accepts on this cycle.
- a, b  in  WIDTH  operands.
- alu_ctrl  in  4  operation select (encoding below).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- eq  out  1  a == b at issue (BEQ/BNE), for every op.
- neg  out  1  result[WIDTH-1].
- carry  out  1  ADD: carry-out. SUB: 1 when a ≥ b unsigned. Otherwise 0.
- ovf  out  1  signed overflow for ADD/SUB. Otherwise 0.

## Operation
- Op encoding:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR. These four are unchanged from the previous ALU.
  - 0100 XOR.
  - 0101 SLT (signed, result 1 or 0); 0110 SLTU (unsigned, result 1 or 0).
  - 0111 SLL; 1000 SRL; 1001 SRA. Shift amount is b[SHW-1:0]; upper bits of b are ignored.
  - 1010 MUL: low WIDTH bits of the unsigned product.
  - 1011 MULHU: high WIDTH bits of the 2·WIDTH unsigned product.
  - 1100–1111: result 0, flags computed normally (zero = 1).
- All arithmetic is modulo 2^WIDTH.
- FSM states: IDLE, MUL, DONE.
  - out_valid = (state == DONE).
  - in_ready = !rst & !flush & (state == IDLE | (state == DONE & out_ready)).
- Accept = in_valid & in_ready.
  - Single-cycle op: next state DONE; result and flags load.
  - MUL/MULHU: next state MUL; operands latch; accumulator clears; step counter = 0.
- MUL state:
  - Each cycle performs one shift-add step and increments the counter.
  - The step with counter == WIDTH-1 moves to DONE and loads result and flags.
  - in_ready = 0 throughout.
- DONE state:
  - result and flags hold while out_ready = 0.
  - out_ready = 1 without a new accept: next state IDLE.
  - out_ready = 1 with a new accept: back-to-back issue as above.
- flush (any state): next state IDLE, out_valid = 0 next cycle, no accept that cycle. Multiply progress is discarded. result and flags keep their stale values.
- flush and rst together: rst wins; the effect is identical.
- Operand changes on a, b or alu_ctrl during MUL or DONE have no effect.
- eq is latched at accept.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero/eq/neg/carry/ovf 0, counter 0. in_ready = 0 during rst and 1 in the first cycle after.
- Latency, single-cycle op: out_valid is high in the cycle after the accepting edge.
- Latency, MUL/MULHU: out_valid is high WIDTH edges after the accepting edge.
- Throughput:
  - Single-cycle ops: 1 per clock while out_ready = 1.
  - Multiplies: 1 per WIDTH+1 clocks, because the accept occurs in the DONE cycle.
- rst mid-multiply: IDLE on the next edge, no result produced.
- All outputs are registered, except in_ready, which is combinational from state, out_ready, flush and rst.

## Structure
- Package alu_pkg holds:
  - op localparams (OP_ADD … OP_MULHU, 4-bit);
  - state enum (IDLE, MUL, DONE);
  - flag struct {zero, eq, neg, carry, ovf}.
- Sub-module alu_mul_iter (WIDTH parameter) holds the shift-add datapath:
  - inputs: start, a, b;
  - outputs: 2·WIDTH product, done.
  - The FSM and single-cycle logic stay in alu_iter.

## Test plan
- Reset: hold rst 3 cycles with in_valid = 1 → no accept, out_valid = 0, all flags 0. in_ready = 1 on the first cycle after rst.
- WIDTH = 32, back-to-back ADD 0x7FFFFFFF+1 then SUB 5−5, with out_ready = 1:
  - first result 0x80000000, ovf = 1, neg = 1, carry = 0, next cycle;
  - second result 0, zero = 1, eq = 1, carry = 1, following cycle.
- SRA 0x80000000 by b = 0x24 (amount 4) → 0xF8000000. SLT −1 vs 1 → 1. SLTU of the same operands → 0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF:
  - in_ready = 0 for 32 cycles;
  - out_valid appears 32 edges after accept with result 0xFFFFFFFE;
  - MUL of the same operands gives 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE → result stable, in_ready = 0. Then assert out_ready with in_valid = 1 → accept in that cycle.
- flush at MUL step 10, then in_valid with ADD 2+3 → IDLE, no multiply result ever appears; next result 5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, FSM states and status flag layout for alu_iter
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLT   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_SLL   = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic eq;
        logic neg;
        logic carry;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one partial product per clock, WIDTH steps per product
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;
    logic [SHW-1:0]     cnt;
    logic [WIDTH:0]     sum;

    // product is the value after the step taking place this cycle, so the
    // caller can capture the final product on the same edge as the last step
    always_comb begin
        sum     = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? mcand : {WIDTH{1'b0}})};
        product = {sum, p[WIDTH-1:1]};
        done    = cnt == SHW'(WIDTH - 1);
    end

    // start loads multiplicand and multiplier; otherwise step every clock
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            p     <= '0;
            cnt   <= '0;
        end else if (start) begin
            mcand <= a;
            p     <= {{WIDTH{1'b0}}, b};
            cnt   <= '0;
        end else begin
            p     <= product;
            cnt   <= cnt + SHW'(1);
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: handshaked execute-stage ALU with registered flags and iterative multiply
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             eq,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state, state_n;
    flags_t             flg, s_flg, m_flg;
    logic [WIDTH-1:0]   s_res, m_res;
    logic [WIDTH:0]     sum, diff;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] prod;
    logic               mdone, accept, is_mul, hi_sel, eq_l;

    assign accept = in_valid && in_ready;
    assign is_mul = alu_ctrl == OP_MUL || alu_ctrl == OP_MULHU;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .product (prod),
        .done    (mdone)
    );

    // single-cycle result and flags straight from the presented operands
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        shamt = b[SHW-1:0];
        case (alu_ctrl)
            OP_ADD:  s_res = sum[WIDTH-1:0];
            OP_SUB:  s_res = diff[WIDTH-1:0];
            OP_AND:  s_res = a & b;
            OP_OR:   s_res = a | b;
            OP_XOR:  s_res = a ^ b;
            OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: s_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:  s_res = a << shamt;
            OP_SRL:  s_res = a >> shamt;
            OP_SRA:  s_res = $unsigned($signed(a) >>> shamt);
            default: s_res = '0;
        endcase
        s_flg.zero  = s_res == '0;
        s_flg.eq    = a == b;
        s_flg.neg   = s_res[WIDTH-1];
        s_flg.carry = alu_ctrl == OP_ADD ? sum[WIDTH] :
                      alu_ctrl == OP_SUB ? !diff[WIDTH] : 1'b0;
        s_flg.ovf   = alu_ctrl == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
                      alu_ctrl == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    end

    // multiply result selection; eq comes from the operands latched at accept
    always_comb begin
        m_res       = hi_sel ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        m_flg.zero  = m_res == '0;
        m_flg.eq    = eq_l;
        m_flg.neg   = m_res[WIDTH-1];
        m_flg.carry = 1'b0;
        m_flg.ovf   = 1'b0;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next-state: flush always returns to IDLE and discards multiply progress
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? (is_mul ? MUL : DONE) : IDLE;
            MUL:     state_n = mdone ? DONE : MUL;
            DONE:    state_n = accept ? (is_mul ? MUL : DONE) : (out_ready ? IDLE : DONE);
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // handshake outputs
    always_comb begin
        out_valid = state == DONE;
        in_ready  = !rst && !flush && (state == IDLE || (state == DONE && out_ready));
    end

    // result/flag registers; they hold across DONE stalls and keep stale values on flush
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            flg    <= '0;
            hi_sel <= 1'b0;
            eq_l   <= 1'b0;
        end else if (accept && !is_mul) begin
            result <= s_res;
            flg    <= s_flg;
        end else if (accept) begin
            hi_sel <= alu_ctrl == OP_MULHU;
            eq_l   <= a == b;
        end else if (state == MUL && mdone && !flush) begin
            result <= m_res;
            flg    <= m_flg;
        end
    end

    assign zero  = flg.zero;
    assign eq    = flg.eq;
    assign neg   = flg.neg;
    assign carry = flg.carry;
    assign ovf   = flg.ovf;

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed table vectors plus hand sequences for multiply, backpressure, flush and reset
module tb_alu_iter;
    import alu_pkg::*;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, result;
    logic [3:0]  alu_ctrl;
    logic        zero, eq, neg, carry, ovf;
    int          checks = 0;
    int          failures = 0;

    alu_iter #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .eq        (eq),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    vec_t vecs[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        in_valid = v;
        alu_ctrl = op;
        a        = x;
        b        = y;
    endtask

    function automatic logic [4:0] flags();
        return {zero, eq, neg, carry, ovf};
    endfunction

    initial begin
        int n, bad;
        logic [31:0] held;
        // flags column is {zero, eq, neg, carry, ovf}
        vecs[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b00101};
        vecs[1]  = '{OP_SUB,   32'h00000005, 32'h00000005, 32'h00000000, 5'b11010};
        vecs[2]  = '{OP_SRA,   32'h80000000, 32'h00000024, 32'hF8000000, 5'b00100};
        vecs[3]  = '{OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000};
        vecs[4]  = '{OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10000};
        vecs[5]  = '{OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000};
        vecs[6]  = '{OP_OR,    32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 5'b00100};
        vecs[7]  = '{OP_XOR,   32'h12345678, 32'h12345678, 32'h00000000, 5'b11000};
        vecs[8]  = '{OP_SLL,   32'h00000001, 32'h0000001F, 32'h80000000, 5'b00100};
        vecs[9]  = '{OP_SRL,   32'h80000000, 32'h0000001F, 32'h00000001, 5'b00000};
        vecs[10] = '{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10010};
        vecs[11] = '{OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b00100};
        vecs[12] = '{OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00011};
        vecs[13] = '{4'b1100,  32'h00000003, 32'h00000003, 32'h00000000, 5'b11000};
        vecs[14] = '{OP_ADD,   32'h00000003, 32'h00000004, 32'h00000007, 5'b00000};
        vecs[15] = '{OP_SLT,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b10000};
        vecs[16] = '{OP_SRA,   32'h7FFFFFFF, 32'hFFFFFFE1, 32'h3FFFFFFF, 5'b00000};

        // reset held 3 cycles with a valid request pending
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_flags", {result, 3'b0, flags()}, 0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);
        step();
        chk("post_rst_no_accept", out_valid, 0);

        // back-to-back single-cycle ops, one result per clock
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].res);
            chk($sformatf("vec%0d_flags", i), flags(), vecs[i].fl);
        end
        in_valid = 1'b0;
        step();
        chk("drain_idle", out_valid, 0);

        // MULHU with operand churn and backpressure held afterwards
        drive(1'b1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        chk("mulhu_in_ready", in_ready, 1);
        step();
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 32'h1234, 32'h5678);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
            step();
        end
        chk("mulhu_busy_cycles", bad, 0);
        chk("mulhu_valid", out_valid, 1);
        chk("mulhu_result", result, 32'hFFFFFFFE);
        chk("mulhu_flags", flags(), 5'b01100);

        held = result;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        chk("backpressure_hold", bad, 0);

        // release with a new MUL accepted in the DONE cycle
        out_ready = 1'b1;
        drive(1'b1, OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        chk("done_accept", in_ready, 1);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk("mul_latency", n, 32);
        chk("mul_result", result, 32'h00000001);
        chk("mul_flags", flags(), 5'b01000);
        step();
        chk("mul_retire", out_valid, 0);

        // flush at multiply step 10, with a request offered during flush
        drive(1'b1, OP_MUL, 32'd7, 32'd9);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        flush = 1'b1;
        drive(1'b1, OP_ADD, 32'd2, 32'd3);
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_stale_result", result, 32'h00000001);
        step();
        in_valid = 1'b0;
        chk("after_flush_valid", out_valid, 1);
        chk("after_flush_result", result, 32'd5);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        chk("flush_no_mul_result", bad, 0);

        // rst mid-multiply
        drive(1'b1, OP_MUL, 32'd6, 32'd7);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_result", result, 0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        chk("rst_mid_no_result", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
